// File: rtl/boot_pkg.sv
// Shared types for the J1 boot sequencer: FSM state encoding and the
// state-decode helper used by the status outputs.
package boot_pkg;

    localparam int unsigned IDX_W = 13;

    typedef enum logic [2:0] {
        BOOT    = 3'd0,
        FETCH   = 3'd1,
        WRITE   = 3'd2,
        RELEASE = 3'd3,
        RUN     = 3'd4,
        ERROR   = 3'd5
    } boot_state_t;

    function automatic logic state_is_busy(input boot_state_t s);
        return (s == FETCH) || (s == WRITE) || (s == RELEASE);
    endfunction

endpackage

// File: rtl/j1_boot_ctrl.sv
// J1 boot sequencer: copies a fixed-length image from a Wishbone read source
// into instruction RAM while holding the core in reset, then releases it.
module j1_boot_ctrl
    import boot_pkg::*;
#(
    parameter int unsigned LOAD_WORDS = 8192,
    parameter logic [31:0] SRC_BASE   = 32'h0000_0000,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic [31:0] wbm_adr_o,
    input  logic [15:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic        ram_we,
    output logic [12:0] ram_adr,
    output logic [15:0] ram_dat,
    output logic        core_reset,
    output logic        busy,
    output logic        done,
    output logic        error
);

    // The timeout counter is never narrower than 8 bits.
    localparam int unsigned TMO_CLOG = $clog2(TIMEOUT + 1);
    localparam int unsigned TMO_W    = (TMO_CLOG > 8) ? TMO_CLOG : 8;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LOAD_WORDS - 1);
    localparam logic             TMO_EN   = (TIMEOUT != 0);

    boot_state_t       state_r;
    boot_state_t       state_nxt_s;
    logic [IDX_W-1:0]  index_r;
    logic [TMO_W-1:0]  tmo_r;
    logic [15:0]       data_r;
    logic              tmo_hit_s;

    // Timeout fires on the TIMEOUT-th consecutive FETCH cycle without a response.
    assign tmo_hit_s = TMO_EN && (tmo_r == TMO_LAST);

    // Next-state selection; err has priority over ack.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            BOOT: begin
                state_nxt_s = FETCH;
            end
            FETCH: begin
                if (wbm_err_i) begin
                    state_nxt_s = ERROR;
                end else if (wbm_ack_i) begin
                    state_nxt_s = WRITE;
                end else if (tmo_hit_s) begin
                    state_nxt_s = ERROR;
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            WRITE: begin
                if (index_r == IDX_LAST) begin
                    state_nxt_s = RELEASE;
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            RELEASE: begin
                state_nxt_s = RUN;
            end
            RUN: begin
                if (start) begin
                    state_nxt_s = BOOT;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            ERROR: begin
                if (start) begin
                    state_nxt_s = BOOT;
                end else begin
                    state_nxt_s = ERROR;
                end
            end
            default: begin
                state_nxt_s = BOOT;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= BOOT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Word index and timeout counter; index stays frozen in ERROR so the
    // failing word remains visible on ram_adr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index_r <= {IDX_W{1'b0}};
            tmo_r   <= {TMO_W{1'b0}};
        end else begin
            case (state_r)
                BOOT: begin
                    index_r <= {IDX_W{1'b0}};
                    tmo_r   <= {TMO_W{1'b0}};
                end
                FETCH: begin
                    if (!wbm_err_i && !wbm_ack_i && TMO_EN) begin
                        tmo_r <= tmo_r + {{(TMO_W-1){1'b0}}, 1'b1};
                    end
                end
                WRITE: begin
                    tmo_r <= {TMO_W{1'b0}};
                    if (index_r != IDX_LAST) begin
                        index_r <= index_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    index_r <= index_r;
                    tmo_r   <= tmo_r;
                end
            endcase
        end
    end

    // Capture read data on a clean acknowledge only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_r <= 16'h0000;
        end else if ((state_r == FETCH) && wbm_ack_i && !wbm_err_i) begin
            data_r <= wbm_dat_i;
        end else begin
            data_r <= data_r;
        end
    end

    assign wbm_cyc_o  = (state_r == FETCH);
    assign wbm_stb_o  = wbm_cyc_o;
    assign wbm_adr_o  = SRC_BASE + {19'd0, index_r};
    assign ram_we     = (state_r == WRITE);
    assign ram_adr    = index_r;
    assign ram_dat    = data_r;
    assign core_reset = (state_r != RUN);
    assign busy       = state_is_busy(state_r);
    assign done       = (state_r == RUN);
    assign error      = (state_r == ERROR);

endmodule

// File: tb/tb_j1_boot_ctrl.sv
// Directed bench for j1_boot_ctrl: scenario table with a behavioural Wishbone
// slave, plus hand sequences for reset/start interactions and TIMEOUT=0.
module tb_j1_boot_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        cyc, stb, ack, err, ram_we, core_reset, busy, done, error;
    logic [31:0] adr;
    logic [15:0] dat, ram_dat;
    logic [12:0] ram_adr;

    logic        cyc0, stb0, ram_we0, core_reset0, busy0, done0, error0;
    logic [31:0] adr0;
    logic [12:0] ram_adr0;
    logic [15:0] ram_dat0;

    always #5 clk = ~clk;

    j1_boot_ctrl #(.LOAD_WORDS(4), .SRC_BASE(32'h0000_0100), .TIMEOUT(5)) dut (
        .clk(clk), .reset(reset), .start(start),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_adr_o(adr),
        .wbm_dat_i(dat), .wbm_ack_i(ack), .wbm_err_i(err),
        .ram_we(ram_we), .ram_adr(ram_adr), .ram_dat(ram_dat),
        .core_reset(core_reset), .busy(busy), .done(done), .error(error)
    );

    j1_boot_ctrl #(.LOAD_WORDS(4), .SRC_BASE(32'h0000_0000), .TIMEOUT(0)) dut0 (
        .clk(clk), .reset(reset), .start(start),
        .wbm_cyc_o(cyc0), .wbm_stb_o(stb0), .wbm_adr_o(adr0),
        .wbm_dat_i(16'h0000), .wbm_ack_i(1'b0), .wbm_err_i(1'b0),
        .ram_we(ram_we0), .ram_adr(ram_adr0), .ram_dat(ram_dat0),
        .core_reset(core_reset0), .busy(busy0), .done(done0), .error(error0)
    );

    // Slave configuration
    logic [15:0] image [4];
    int wait_word = -1, wait_n = 0, err_word = -1, noack_word = -1;
    bit err_en = 1'b0, both = 1'b0, noack_en = 1'b0;
    int wcnt = 0;
    int w;
    logic ack_raw;

    initial begin
        image[0] = 16'h1111; image[1] = 16'h2222;
        image[2] = 16'h3333; image[3] = 16'h4444;
    end

    always_comb begin
        w       = int'(adr - 32'h0000_0100);
        dat     = (w >= 0 && w < 4) ? image[w] : 16'hdead;
        ack_raw = cyc && !(noack_en && w == noack_word) && (w != wait_word || wcnt >= wait_n);
        err     = cyc && err_en && (w == err_word);
        ack     = ack_raw && (!err || both);
    end

    always @(posedge clk) begin
        if (!cyc || ack) wcnt <= 0;
        else             wcnt <= wcnt + 1;
    end

    // Monitor: RAM writes, acked addresses, FETCH cycles of a probed word
    logic [15:0] ram_log [4];
    int          wr_cnt = 0;
    int          probe_word = 0;
    int          probe_cnt = 0;
    int          first_wr_adr = -1;
    logic [31:0] ack_log [$];

    always @(negedge clk) begin
        if (ram_we) begin
            if (ram_adr < 13'd4) ram_log[ram_adr[1:0]] = ram_dat;
            if (wr_cnt == 0) first_wr_adr = int'(ram_adr);
            wr_cnt++;
        end
        if (cyc && ack) ack_log.push_back(adr);
        if (cyc && w == probe_word) probe_cnt++;
    end

    int n_checks = 0, n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        for (int i = 0; i < 4; i++) ram_log[i] = 16'h0000;
        wr_cnt = 0; probe_cnt = 0; first_wr_adr = -1;
        ack_log.delete();
    endtask

    task automatic cfg(input int ww, input int wn, input int ew, input bit ee,
                       input bit bb, input int nw, input bit ne, input int pw);
        wait_word = ww; wait_n = wn; err_word = ew; err_en = ee;
        both = bb; noack_word = nw; noack_en = ne; probe_word = pw;
    endtask

    task automatic reset_dut();
        @(negedge clk); reset = 1'b1;
        @(posedge clk); clear_logs();
        @(negedge clk); reset = 1'b0;
    endtask

    // Count edges until done or error is seen; expiry counts as a failure.
    task automatic run_until(input int budget, output int n);
        n = 0;
        while (1) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (done || error) break;
            if (n >= budget) begin
                n_checks++; n_errors++;
                $display("FAIL run_timeout: got %0d cycles expected completion", n);
                break;
            end
        end
    endtask

    typedef struct {
        string name;
        int ww, wn, ew; bit ee, bb; int nw; bit ne; int pw;
        int exp_lat, exp_probe; bit exp_done; int exp_radr, exp_writes;
    } vec_t;

    vec_t vecs [5];
    int   n;

    initial begin
        vecs[0] = '{"zero_wait", -1, 0, -1, 1'b0, 1'b0, -1, 1'b0, 2, 10, 1, 1'b1, 3, 4};
        vecs[1] = '{"wait3_w2",   2, 3, -1, 1'b0, 1'b0, -1, 1'b0, 2, 13, 4, 1'b1, 3, 4};
        vecs[2] = '{"err_w1",    -1, 0,  1, 1'b1, 1'b0, -1, 1'b0, 1,  4, 1, 1'b0, 1, 1};
        vecs[3] = '{"ackerr_w2", -1, 0,  2, 1'b1, 1'b1, -1, 1'b0, 2,  6, 1, 1'b0, 2, 2};
        vecs[4] = '{"timeout_w0",-1, 0, -1, 1'b0, 1'b0,  0, 1'b1, 0,  6, 5, 1'b0, 0, 0};

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_cyc_stb", {30'd0, cyc, stb}, 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_adr", 32'(ram_adr), 32'd0);
        chk("rst_ram_dat", 32'(ram_dat), 32'd0);
        chk("rst_flags", {29'd0, busy, done, error}, 32'd0);
        chk("rst_wbm_adr", adr, 32'h0000_0100);

        for (int v = 0; v < 5; v++) begin
            cfg(vecs[v].ww, vecs[v].wn, vecs[v].ew, vecs[v].ee, vecs[v].bb,
                vecs[v].nw, vecs[v].ne, vecs[v].pw);
            reset_dut();
            run_until(100, n);
            chk({vecs[v].name, "_latency"}, 32'(n), 32'(vecs[v].exp_lat));
            chk({vecs[v].name, "_done"}, 32'(done), 32'(vecs[v].exp_done));
            chk({vecs[v].name, "_error"}, 32'(error), 32'(!vecs[v].exp_done));
            chk({vecs[v].name, "_core_reset"}, 32'(core_reset), 32'(!vecs[v].exp_done));
            chk({vecs[v].name, "_probe_fetch"}, 32'(probe_cnt), 32'(vecs[v].exp_probe));
            repeat (5) @(negedge clk);
            chk({vecs[v].name, "_ram_adr"}, 32'(ram_adr), 32'(vecs[v].exp_radr));
            chk({vecs[v].name, "_writes"}, 32'(wr_cnt), 32'(vecs[v].exp_writes));
            chk({vecs[v].name, "_busy"}, 32'(busy), 32'd0);
            for (int i = 0; i < vecs[v].exp_writes; i++)
                chk({vecs[v].name, "_ram_data"}, 32'(ram_log[i]), 32'(image[i]));
            if (vecs[v].exp_done) begin
                chk({vecs[v].name, "_ack_count"}, 32'(ack_log.size()), 32'd4);
                for (int i = 0; i < ack_log.size() && i < 4; i++)
                    chk({vecs[v].name, "_wbm_adr"}, ack_log[i], 32'h0000_0100 + 32'(i));
            end
        end

        // Reload after ERROR via start
        cfg(-1, 0, 1, 1'b1, 1'b0, -1, 1'b0, 0);
        reset_dut();
        run_until(100, n);
        chk("err_then_error", 32'(error), 32'd1);
        err_en = 1'b0;
        start = 1'b1;
        @(posedge clk); clear_logs();
        @(negedge clk); start = 1'b0;
        chk("err_start_boot", {30'd0, error, busy}, 32'd0);
        run_until(100, n);
        chk("err_reload_latency", 32'(n), 32'd10);
        chk("err_reload_done", 32'(done), 32'd1);
        chk("err_reload_writes", 32'(wr_cnt), 32'd4);
        chk("err_reload_first", 32'(first_wr_adr), 32'd0);

        // start in RUN raises core_reset at the next edge and reloads
        start = 1'b1;
        @(posedge clk); clear_logs();
        @(negedge clk); start = 1'b0;
        chk("run_start_core_reset", 32'(core_reset), 32'd1);
        run_until(100, n);
        chk("run_reload_latency", 32'(n), 32'd10);
        chk("run_reload_writes", 32'(wr_cnt), 32'd4);
        chk("run_reload_word3", 32'(ram_log[3]), 32'(image[3]));

        // Async reset while fetching word 2 restarts from word 0
        cfg(2, 2, -1, 1'b0, 1'b0, -1, 1'b0, 0);
        reset_dut();
        n = 0;
        while (!(cyc && adr == 32'h0000_0102) && n < 20) begin
            @(posedge clk); n++; @(negedge clk);
        end
        chk("midreset_reached_w2", 32'(cyc && adr == 32'h0000_0102), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("midreset_async_core_reset", 32'(core_reset), 32'd1);
        chk("midreset_async_cyc", 32'(cyc), 32'd0);
        chk("midreset_async_ram_adr", 32'(ram_adr), 32'd0);
        cfg(-1, 0, -1, 1'b0, 1'b0, -1, 1'b0, 0);
        @(posedge clk); clear_logs();
        @(negedge clk); reset = 1'b0;
        run_until(100, n);
        chk("midreset_latency", 32'(n), 32'd10);
        chk("midreset_first_write", 32'(first_wr_adr), 32'd0);
        chk("midreset_writes", 32'(wr_cnt), 32'd4);

        // start during FETCH is ignored
        reset_dut();
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (n == 3) begin
                chk("fetch_start_in_fetch", 32'(cyc), 32'd1);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("fetch_start_latency", 32'(n), 32'd10);
        chk("fetch_start_writes", 32'(wr_cnt), 32'd4);

        // TIMEOUT=0 instance waits indefinitely without ack
        reset_dut();
        repeat (300) @(negedge clk);
        chk("tmo0_cyc_stb", {30'd0, cyc0, stb0}, 32'd3);
        chk("tmo0_flags", {27'd0, busy0, done0, error0, core_reset0, ram_we0}, 32'b10010);
        chk("tmo0_adr", adr0 | 32'(ram_adr0) | 32'(ram_dat0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
